// File: rtl/aer_event_encoder_pkg.sv
// Shared types, default widths and helpers for the AER event encoder.
// Defining EVT_TIMESTAMP_EN adds a timestamp field to every event word.
package aer_event_encoder_pkg;

   localparam int ROW_ADD_DEF    = 3;
   localparam int COL_ADD_DEF    = 3;
   localparam int TS_W_DEF       = 16;
   localparam int FIFO_DEPTH_DEF = 4;

`ifdef EVT_TIMESTAMP_EN
   localparam bit TS_EN = 1'b1;
`else
   localparam bit TS_EN = 1'b0;
`endif

   localparam logic EVT_POL_ON  = 1'b1;
   localparam logic EVT_POL_OFF = 1'b0;

   typedef enum logic [1:0] {
      EMPTY,
      HOLD,
      STREAM
   } evt_state_t;

   typedef struct packed {
      logic [ROW_ADD_DEF-1:0] row;
      logic [COL_ADD_DEF-1:0] col;
      logic                   pol;
   } aer_evt_t;

   // Event word width; the timestamp field only exists when enabled.
   function automatic int evt_width(int row_w, int col_w, int ts_w);
      return row_w + col_w + 1 + (TS_EN ? ts_w : 0);
   endfunction

endpackage

// File: rtl/aer_event_encoder_if.sv
// Arbiter-side inputs and event-stream outputs of the AER event encoder.
// The slave modport is the encoder's view; master is the surrounding logic.
interface aer_event_encoder_if #(
   parameter int ROW_ADD = aer_event_encoder_pkg::ROW_ADD_DEF,
   parameter int COL_ADD = aer_event_encoder_pkg::COL_ADD_DEF,
   parameter int EVT_W   = aer_event_encoder_pkg::evt_width(ROW_ADD, COL_ADD,
                                                            aer_event_encoder_pkg::TS_W_DEF),
   parameter int PTR_W   = $clog2(aer_event_encoder_pkg::FIFO_DEPTH_DEF)
);

   logic [ROW_ADD-1:0] row_add_i;
   logic               col_gnt_vld_i;
   logic [COL_ADD-1:0] col_add_i;
   logic               polarity_i;
   logic               evt_ready_i;
   logic               evt_valid_o;
   logic [EVT_W-1:0]   evt_data_o;
   logic               col_enable_o;
   logic [PTR_W:0]     fifo_level_o;
   logic               overflow_o;

   modport slave (
      input  row_add_i, col_gnt_vld_i, col_add_i, polarity_i, evt_ready_i,
      output evt_valid_o, evt_data_o, col_enable_o, fifo_level_o, overflow_o
   );

   modport master (
      output row_add_i, col_gnt_vld_i, col_add_i, polarity_i, evt_ready_i,
      input  evt_valid_o, evt_data_o, col_enable_o, fifo_level_o, overflow_o
   );

endinterface

// File: rtl/aer_event_encoder_event_fifo.sv
// First-word-fall-through FIFO with occupancy count; DEPTH must be a power of 2.
// A push into a full FIFO is accepted only when a pop frees the head that cycle.
module event_fifo #(
   parameter  int WIDTH = 7,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             push_ok_o,
   output logic [WIDTH-1:0] rdata_o,
   output logic [PTR_W:0]   level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   level_q;
   logic             empty, full, pop_ok;

   assign empty     = (level_q == '0);
   assign full      = (level_q == (PTR_W+1)'(DEPTH));
   assign pop_ok    = pop_i && !empty;
   assign push_ok_o = push_i && (!full || pop_ok);

   // NOTE: state updates use <= so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok_o) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_ok_o, pop_ok})
            2'b10:   level_q <= level_q + (PTR_W+1)'(1);
            2'b01:   level_q <= level_q - (PTR_W+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // NOTE: storage is not reset; the empty-gated read port hides stale entries.
   always_ff @(posedge clk_i) begin
      if (push_ok_o) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
   assign level_o = level_q;

endmodule

// File: rtl/aer_event_encoder.sv
// Packs column/row grants into AER words, buffers them and throttles the arbiter.
// Defining EVT_TIMESTAMP_EN prepends a free-running timestamp to each word.
module aer_event_encoder
   import aer_event_encoder_pkg::*;
#(
   parameter  int ROW_ADD    = ROW_ADD_DEF,
   parameter  int COL_ADD    = COL_ADD_DEF,
   parameter  int TS_W       = TS_W_DEF,
   parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int PTR_W      = $clog2(FIFO_DEPTH),
   localparam int EVT_W      = evt_width(ROW_ADD, COL_ADD, TS_W)
) (
   input  logic                clk_i,
   input  logic                reset_i,
   aer_event_encoder_if.slave  bus
);

   localparam logic [PTR_W:0] LVL_ONE    = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] LVL_THRESH = (PTR_W+1)'(FIFO_DEPTH - 2);

   logic [EVT_W-1:0] word_d, head;
   logic [PTR_W:0]   level;
   logic             push, pop, push_ok, evt_valid;
   logic             overflow_q, overflow_d;
   evt_state_t       fsm_state_q, fsm_state_d;

   assign push      = bus.col_gnt_vld_i;
   assign evt_valid = (level != '0);
   assign pop       = evt_valid && bus.evt_ready_i;

`ifdef EVT_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) ts_q <= '0;
      else         ts_q <= ts_q + TS_W'(1);
   end

   assign word_d = {ts_q, bus.row_add_i, bus.col_add_i, bus.polarity_i};
`else
   assign word_d = {bus.row_add_i, bus.col_add_i, bus.polarity_i};
`endif

   event_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .push_i    (push),
      .pop_i     (pop),
      .wdata_i   (word_d),
      .push_ok_o (push_ok),
      .rdata_o   (head),
      .level_o   (level)
   );

   // A grant the FIFO cannot take is lost; remember that until reset.
   assign overflow_d = overflow_q | (push && !push_ok);

   // NOTE: defaults first so no path through the case leaves a latch.
   always_comb begin
      fsm_state_d = fsm_state_q;
      unique case (fsm_state_q)
         EMPTY:  if (push) fsm_state_d = HOLD;
         HOLD:   if (bus.evt_ready_i) begin
                    if (level > LVL_ONE)                fsm_state_d = STREAM;
                    else if (level == LVL_ONE && !push) fsm_state_d = EMPTY;
                 end
         STREAM: if (!bus.evt_ready_i)                  fsm_state_d = HOLD;
                 else if (level == LVL_ONE && !push)    fsm_state_d = EMPTY;
         default: fsm_state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         fsm_state_q <= EMPTY;
         overflow_q  <= 1'b0;
      end else begin
         fsm_state_q <= fsm_state_d;
         overflow_q  <= overflow_d;
      end
   end

   // The FSM is EMPTY exactly when the buffer holds nothing.
   always_comb begin
      if (!reset_i) assert ((fsm_state_q == EMPTY) == (level == '0));
   end

   assign bus.evt_valid_o  = evt_valid;
   assign bus.evt_data_o   = head;
   assign bus.fifo_level_o = level;
   assign bus.col_enable_o = (level <= LVL_THRESH);
   assign bus.overflow_o   = overflow_q;

endmodule

// File: tb/tb_aer_event_encoder.sv
// Directed self-checking bench for aer_event_encoder (depth 4, 3-bit addresses).
// Timestamp checks are compiled in when EVT_TIMESTAMP_EN is defined (TS_W = 4).
module tb_aer_event_encoder;
   import aer_event_encoder_pkg::*;

   localparam int ROW   = 3;
   localparam int COL   = 3;
   localparam int TS    = 4;
   localparam int DEPTH = 4;
   localparam int PTR   = $clog2(DEPTH);
   localparam int EW    = evt_width(ROW, COL, TS);
   localparam int AW    = ROW + COL + 1;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   aer_event_encoder_if #(.ROW_ADD(ROW), .COL_ADD(COL), .EVT_W(EW), .PTR_W(PTR)) bus ();

   aer_event_encoder #(
      .ROW_ADD    (ROW),
      .COL_ADD    (COL),
      .TS_W       (TS),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [AW-1:0] word(input logic [2:0] r, input logic [2:0] c, input logic p);
      aer_evt_t e;
      e.row = r;
      e.col = c;
      e.pol = p;
      return e;
   endfunction

   function automatic logic [AW-1:0] head();
      return bus.evt_data_o[AW-1:0];
   endfunction

   task automatic drive(input logic gnt, input logic [AW-1:0] w);
      bus.col_gnt_vld_i = gnt;
      bus.row_add_i     = w[AW-1 -: ROW];
      bus.col_add_i     = w[COL:1];
      bus.polarity_i    = w[0];
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.evt_ready_i = 1'b0;
      drive(1'b0, '0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_vec++; if (bus.evt_valid_o !== 1'b0) begin n_err++; $display("FAIL reset.valid got=%b exp=0", bus.evt_valid_o); end
      n_vec++; if (bus.col_enable_o !== 1'b1) begin n_err++; $display("FAIL reset.enable got=%b exp=1", bus.col_enable_o); end
      n_vec++; if (bus.fifo_level_o !== 3'd0) begin n_err++; $display("FAIL reset.level got=%0d exp=0", bus.fifo_level_o); end
      n_vec++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL reset.overflow got=%b exp=0", bus.overflow_o); end
      n_vec++; if (bus.evt_data_o !== '0) begin n_err++; $display("FAIL reset.data got=%h exp=0", bus.evt_data_o); end
   endtask

   task automatic test_single();
      bus.evt_ready_i = 1'b1;
      drive(1'b1, word(3'd5, 3'd2, EVT_POL_ON));
      @(negedge clk);
      drive(1'b0, '0);
      n_vec++; if (bus.evt_valid_o !== 1'b1) begin n_err++; $display("FAIL single.valid got=%b exp=1", bus.evt_valid_o); end
      n_vec++; if (head() !== 7'b101_010_1) begin n_err++; $display("FAIL single.data got=%b exp=1010101", head()); end
      n_vec++; if (bus.fifo_level_o !== 3'd1) begin n_err++; $display("FAIL single.level got=%0d exp=1", bus.fifo_level_o); end
      @(negedge clk);
      n_vec++; if (bus.evt_valid_o !== 1'b0) begin n_err++; $display("FAIL single.drained got=%b exp=0", bus.evt_valid_o); end
      n_vec++; if (bus.fifo_level_o !== 3'd0) begin n_err++; $display("FAIL single.level0 got=%0d exp=0", bus.fifo_level_o); end
      n_vec++; if (bus.evt_data_o !== '0) begin n_err++; $display("FAIL single.data0 got=%h exp=0", bus.evt_data_o); end
      bus.evt_ready_i = 1'b0;
   endtask

   logic [AW-1:0] thr_w [4];

   task automatic test_throttle();
      logic exp_en [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      thr_w[0] = word(3'd1, 3'd1, EVT_POL_OFF);
      thr_w[1] = word(3'd2, 3'd3, EVT_POL_ON);
      thr_w[2] = word(3'd3, 3'd4, EVT_POL_OFF);
      thr_w[3] = word(3'd4, 3'd5, EVT_POL_ON);
      bus.evt_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, thr_w[i]);
         @(negedge clk);
         n_vec++; if (bus.fifo_level_o !== 3'(i + 1)) begin n_err++; $display("FAIL throttle.level[%0d] got=%0d exp=%0d", i, bus.fifo_level_o, i + 1); end
         n_vec++; if (bus.col_enable_o !== exp_en[i]) begin n_err++; $display("FAIL throttle.enable[%0d] got=%b exp=%b", i, bus.col_enable_o, exp_en[i]); end
         n_vec++; if (head() !== thr_w[0]) begin n_err++; $display("FAIL throttle.head[%0d] got=%h exp=%h", i, head(), thr_w[0]); end
         n_vec++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL throttle.overflow[%0d] got=%b exp=0", i, bus.overflow_o); end
      end
      drive(1'b0, '0);
   endtask

   task automatic test_overflow();
      drive(1'b1, word(3'd6, 3'd6, EVT_POL_ON));
      @(negedge clk);
      drive(1'b0, '0);
      n_vec++; if (bus.overflow_o !== 1'b1) begin n_err++; $display("FAIL overflow.flag got=%b exp=1", bus.overflow_o); end
      n_vec++; if (bus.fifo_level_o !== 3'd4) begin n_err++; $display("FAIL overflow.level got=%0d exp=4", bus.fifo_level_o); end
      bus.evt_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (head() !== thr_w[i]) begin n_err++; $display("FAIL overflow.drain[%0d] got=%h exp=%h", i, head(), thr_w[i]); end
         n_vec++; if (bus.fifo_level_o !== 3'(4 - i)) begin n_err++; $display("FAIL overflow.dlevel[%0d] got=%0d exp=%0d", i, bus.fifo_level_o, 4 - i); end
         @(negedge clk);
      end
      n_vec++; if (bus.evt_valid_o !== 1'b0) begin n_err++; $display("FAIL overflow.empty got=%b exp=0", bus.evt_valid_o); end
      n_vec++; if (bus.overflow_o !== 1'b1) begin n_err++; $display("FAIL overflow.sticky got=%b exp=1", bus.overflow_o); end
      bus.evt_ready_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      drive(1'b1, word(3'd7, 3'd7, EVT_POL_ON));
      @(negedge clk);
      drive(1'b1, word(3'd2, 3'd2, EVT_POL_OFF));
      @(negedge clk);
      drive(1'b0, '0);
      #2 reset = 1'b1;
      #1;
      n_vec++; if (bus.evt_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid.valid got=%b exp=0", bus.evt_valid_o); end
      n_vec++; if (bus.evt_data_o !== '0) begin n_err++; $display("FAIL rstmid.data got=%h exp=0", bus.evt_data_o); end
      n_vec++; if (bus.fifo_level_o !== 3'd0) begin n_err++; $display("FAIL rstmid.level got=%0d exp=0", bus.fifo_level_o); end
      n_vec++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL rstmid.overflow got=%b exp=0", bus.overflow_o); end
      n_vec++; if (bus.col_enable_o !== 1'b1) begin n_err++; $display("FAIL rstmid.enable got=%b exp=1", bus.col_enable_o); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_push_pop();
      logic [AW-1:0] w [5];
      w[0] = word(3'd7, 3'd0, EVT_POL_ON);
      w[1] = word(3'd0, 3'd7, EVT_POL_OFF);
      w[2] = word(3'd5, 3'd5, EVT_POL_ON);
      w[3] = word(3'd2, 3'd6, EVT_POL_OFF);
      w[4] = word(3'd6, 3'd1, EVT_POL_ON);
      bus.evt_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, w[i]);
         @(negedge clk);
      end
      bus.evt_ready_i = 1'b1;
      drive(1'b1, w[4]);
      @(negedge clk);
      drive(1'b0, '0);
      n_vec++; if (bus.fifo_level_o !== 3'd4) begin n_err++; $display("FAIL pushpop.level got=%0d exp=4", bus.fifo_level_o); end
      n_vec++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL pushpop.overflow got=%b exp=0", bus.overflow_o); end
      for (int i = 1; i < 5; i++) begin
         n_vec++; if (head() !== w[i]) begin n_err++; $display("FAIL pushpop.drain[%0d] got=%h exp=%h", i, head(), w[i]); end
         n_vec++; if (bus.fifo_level_o !== 3'(5 - i)) begin n_err++; $display("FAIL pushpop.dlevel[%0d] got=%0d exp=%0d", i, bus.fifo_level_o, 5 - i); end
         @(negedge clk);
      end
      n_vec++; if (bus.evt_valid_o !== 1'b0) begin n_err++; $display("FAIL pushpop.empty got=%b exp=0", bus.evt_valid_o); end
      bus.evt_ready_i = 1'b0;
   endtask

`ifdef EVT_TIMESTAMP_EN
   task automatic test_timestamp();
      reset = 1'b1;
      bus.evt_ready_i = 1'b0;
      drive(1'b0, '0);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 19; c++) begin
         drive((c == 3) || (c == 18), word(3'd1, 3'd2, EVT_POL_ON));
         @(negedge clk);
      end
      drive(1'b0, '0);
      n_vec++; if (bus.fifo_level_o !== 3'd2) begin n_err++; $display("FAIL ts.level got=%0d exp=2", bus.fifo_level_o); end
      n_vec++; if (bus.evt_data_o[EW-1 -: TS] !== 4'd3) begin n_err++; $display("FAIL ts.first got=%0d exp=3", bus.evt_data_o[EW-1 -: TS]); end
      bus.evt_ready_i = 1'b1;
      @(negedge clk);
      n_vec++; if (bus.evt_data_o[EW-1 -: TS] !== 4'd2) begin n_err++; $display("FAIL ts.wrap got=%0d exp=2", bus.evt_data_o[EW-1 -: TS]); end
      @(negedge clk);
      bus.evt_ready_i = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_throttle();
      test_overflow();
      test_reset_mid();
      test_full_push_pop();
`ifdef EVT_TIMESTAMP_EN
      test_timestamp();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
